// File: rtl/skinny_sbox8_hpc2_1_pipelined_array_if.sv
// Handshake and share bus for the pipelined masked SKINNY-128 S-box array.
// Input side: valid/ready plus two data shares and fresh randomness. Output side: valid/ready plus two result shares.
interface skinny_sbox8_hpc2_1_pipelined_array_if #(
    parameter int NSBOX = 16
);
    localparam int W = 8 * NSBOX;

    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          si0;
    logic [W-1:0]          si1;
    logic [16*NSBOX-1:0]   r;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          bo0;
    logic [W-1:0]          bo1;
    logic                  busy;

    modport master (
        output in_valid, si0, si1, r, out_ready,
        input  in_ready, out_valid, bo0, bo1, busy
    );

    modport slave (
        input  in_valid, si0, si1, r, out_ready,
        output in_ready, out_valid, bo0, bo1, busy
    );
endinterface

// File: rtl/skinny_sbox8_hpc2_1_pipelined_array.sv
// NSBOX-lane first-order HPC2-masked SKINNY-128 S8 array, fully pipelined with 8 register stages.
// Defining SKINNY_SBOX_PIPE_FLUSH_EN adds a flush input that drops every in-flight beat.

// Masked G(x,y,z) = NOR(x,y)^z: AND of (~x,~y) over two register stages, z added afterwards.
module skinny_sbox8_hpc2_gadget (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       x0,
    input  logic       x1,
    input  logic       y0,
    input  logic       y1,
    input  logic       z0,
    input  logic       z1,
    input  logic [1:0] rnd,
    output logic       g0,
    output logic       g1
);
    logic xa0, xa1, yb0, yb1, ry0, ry1, rd0, rd1, zd0, zd1;
    logic in0, in1, nr0, nr1, cr0, cr1, zq0, zq1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {xa0, xa1, yb0, yb1, ry0, ry1, rd0, rd1, zd0, zd1} <= '0;
            {in0, in1, nr0, nr1, cr0, cr1, zq0, zq1} <= '0;
        end else if (en) begin
            xa0 <= ~x0;
            xa1 <= x1;
            yb0 <= ~y0;
            yb1 <= y1;
            ry0 <= ~y0 ^ rnd[1];
            ry1 <= y1 ^ rnd[1];
            rd0 <= rnd[0];
            rd1 <= rnd[1];
            zd0 <= z0;
            zd1 <= z1;
            in0 <= (xa0 & yb0) ^ rd0;
            in1 <= (xa1 & yb1) ^ rd0;
            nr0 <= ~xa0 & rd1;
            nr1 <= ~xa1 & rd1;
            cr0 <= xa0 & ry1;
            cr1 <= xa1 & ry0;
            zq0 <= zd0;
            zq1 <= zd1;
        end
    end

    assign g0 = in0 ^ nr0 ^ cr0 ^ zq0;
    assign g1 = in1 ^ nr1 ^ cr1 ^ zq1;
endmodule

module skinny_sbox8_hpc2_dly2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mid <= '0;
            q   <= '0;
        end else if (en) begin
            mid <= d;
            q   <= mid;
        end
    end
endmodule

module skinny_sbox8_hpc2_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [15:0] rnd,
    output logic [7:0]  o0,
    output logic [7:0]  o1
);
    logic [7:0]  a_s0, a_s1;
    logic [19:0] q1;
    logic [17:0] q2;
    logic [13:0] q3, q4;
    logic [7:0]  fin0, fin1;

    skinny_sbox8_hpc2_gadget u_a0 (.clk, .rst_n, .en, .x0(b0[7]), .x1(b1[7]), .y0(b0[6]), .y1(b1[6]),
        .z0(b0[4]), .z1(b1[4]), .rnd(rnd[1:0]), .g0(a_s0[0]), .g1(a_s1[0]));
    skinny_sbox8_hpc2_gadget u_a1 (.clk, .rst_n, .en, .x0(b0[3]), .x1(b1[3]), .y0(b0[2]), .y1(b1[2]),
        .z0(b0[0]), .z1(b1[0]), .rnd(rnd[3:2]), .g0(a_s0[1]), .g1(a_s1[1]));
    skinny_sbox8_hpc2_gadget u_a2 (.clk, .rst_n, .en, .x0(b0[2]), .x1(b1[2]), .y0(b0[1]), .y1(b1[1]),
        .z0(b0[6]), .z1(b1[6]), .rnd(rnd[5:4]), .g0(a_s0[2]), .g1(a_s1[2]));
    // Each level forwards only what later levels still need: b{7,5,3,2,1} per share and r[15:6].
    skinny_sbox8_hpc2_dly2 #(.W(20)) u_c1 (.clk, .rst_n, .en, .q(q1),
        .d({b0[7], b0[5], b0[3], b0[2], b0[1], b1[7], b1[5], b1[3], b1[2], b1[1], rnd[15:6]}));

    skinny_sbox8_hpc2_gadget u_a3 (.clk, .rst_n, .en, .x0(a_s0[0]), .x1(a_s1[0]), .y0(a_s0[1]), .y1(a_s1[1]),
        .z0(q1[18]), .z1(q1[13]), .rnd(q1[1:0]), .g0(a_s0[3]), .g1(a_s1[3]));
    skinny_sbox8_hpc2_gadget u_a4 (.clk, .rst_n, .en, .x0(a_s0[1]), .x1(a_s1[1]), .y0(q1[17]), .y1(q1[12]),
        .z0(q1[15]), .z1(q1[10]), .rnd(q1[3:2]), .g0(a_s0[4]), .g1(a_s1[4]));
    skinny_sbox8_hpc2_dly2 #(.W(18)) u_c2 (.clk, .rst_n, .en, .q(q2),
        .d({a_s0[2:0], a_s1[2:0], q1[19], q1[17], q1[16], q1[14], q1[12], q1[11], q1[9:4]}));

    skinny_sbox8_hpc2_gadget u_a5 (.clk, .rst_n, .en, .x0(q2[17]), .x1(q2[14]), .y0(a_s0[3]), .y1(a_s1[3]),
        .z0(q2[11]), .z1(q2[8]), .rnd(q2[1:0]), .g0(a_s0[5]), .g1(a_s1[5]));
    skinny_sbox8_hpc2_gadget u_a6 (.clk, .rst_n, .en, .x0(a_s0[3]), .x1(a_s1[3]), .y0(q2[15]), .y1(q2[12]),
        .z0(q2[10]), .z1(q2[7]), .rnd(q2[3:2]), .g0(a_s0[6]), .g1(a_s1[6]));
    skinny_sbox8_hpc2_dly2 #(.W(14)) u_c3 (.clk, .rst_n, .en, .q(q3),
        .d({a_s0[4:3], q2[17:15], a_s1[4:3], q2[14:12], q2[9], q2[6], q2[5:4]}));

    skinny_sbox8_hpc2_gadget u_a7 (.clk, .rst_n, .en, .x0(q3[13]), .x1(q3[8]), .y0(a_s0[5]), .y1(a_s1[5]),
        .z0(q3[3]), .z1(q3[2]), .rnd(q3[1:0]), .g0(a_s0[7]), .g1(a_s1[7]));
    skinny_sbox8_hpc2_dly2 #(.W(14)) u_c4 (.clk, .rst_n, .en, .q(q4),
        .d({a_s0[6:5], q3[13:9], a_s1[6:5], q3[8:4]}));

    assign fin0 = {a_s0[7], q4[13:7]};
    assign fin1 = {a_s1[7], q4[6:0]};
    assign o0 = {fin0[3], fin0[0], fin0[1], fin0[6], fin0[4], fin0[2], fin0[5], fin0[7]};
    assign o1 = {fin1[3], fin1[0], fin1[1], fin1[6], fin1[4], fin1[2], fin1[5], fin1[7]};
endmodule

module skinny_sbox8_hpc2_1_pipelined_array #(
    parameter int NSBOX = 16
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SKINNY_SBOX_PIPE_FLUSH_EN
    input  logic flush,
`endif
    skinny_sbox8_hpc2_1_pipelined_array_if.slave bus
);
    localparam int LAT = 8;
    localparam int W   = 8 * NSBOX;

    logic           en;
    logic           clr;
    logic           accept;
    logic [LAT-1:0] vld;
    logic [W-1:0]   bo0_w, bo1_w;

`ifdef SKINNY_SBOX_PIPE_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    // A stalled output freezes every stage; bubbles are never squeezed out.
    assign en            = bus.out_ready | ~vld[LAT-1];
    assign bus.in_ready  = en & ~clr;
    assign accept        = bus.in_valid & en & ~clr;
    assign bus.out_valid = vld[LAT-1];
    assign bus.busy      = |vld;
    assign bus.bo0       = bo0_w;
    assign bus.bo1       = bo1_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (clr) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[LAT-2:0], accept};
        end
    end

    for (genvar i = 0; i < NSBOX; i++) begin : g_lane
        skinny_sbox8_hpc2_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .b0    (bus.si0[8*i +: 8]),
            .b1    (bus.si1[8*i +: 8]),
            .rnd   (bus.r[16*i +: 16]),
            .o0    (bo0_w[8*i +: 8]),
            .o1    (bo1_w[8*i +: 8])
        );
    end
endmodule
